burst_mem_responder: RTL and testbench

Responder end of the 4-word burst memory-port protocol that the cache initiators use (req/wren/address/offset/ready). It serves one initiator port from an internal synchronous block RAM. Programmable wait states emulate controller latency. Used as an SDRAM-less memory stand-in for the cache and display-engine benches, and as an on-chip scratch memory port.

---
 rtl/burst_mem_responder.sv | 66 ++++++
 tb/tb_burst_mem_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/burst_mem_responder.sv
// burst_mem_responder: 4-beat burst memory responder over an internal sync RAM; ports clk, reset (sync, active-low), mem_req/mem_wren/mem_address/to_mem in, from_mem/mem_offset/mem_ready/busy out.
module burst_mem_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_wren,
  input  logic [23:0] mem_address,
  input  logic [15:0] to_mem,
  output logic [15:0] from_mem,
  output logic [1:0]  mem_offset,
  output logic        mem_ready,
  output logic        busy
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic [1:0] beat;
  logic [1:0] rd_beat;
  logic [ADDR_WIDTH-3:0] base;
  logic wr;
  logic [15:0] rd_q;
  logic [15:0] ram [2**ADDR_WIDTH];
  logic unused_addr;
  assign unused_addr = ^{mem_address[23:ADDR_WIDTH], mem_address[1:0]};
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = mem_req ? S_WAIT : S_IDLE;
      S_WAIT:  state_nxt = cnt == 4'd0 ? S_BURST : S_WAIT;
      S_BURST: state_nxt = beat == 2'd3 ? S_DONE : S_BURST;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset) state <= S_IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk)
    if (!reset) begin
      cnt  <= 4'd0;
      beat <= 2'd0;
      base <= '0;
      wr   <= 1'b0;
    end else begin
      if (state == S_IDLE && mem_req) begin
        base <= mem_address[ADDR_WIDTH-1:2];
        wr   <= mem_wren;
        cnt  <= 4'(WAIT_CYCLES - 1);
      end
      if (state == S_WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (state == S_WAIT && cnt == 4'd0) beat <= 2'd0;
      if (state == S_BURST && beat != 2'd3) beat <= beat + 2'd1;
    end
  // read port runs one word ahead so each beat's data is already registered when it is presented
  assign rd_beat = state == S_BURST ? beat + 2'd1 : 2'd0;
  always_ff @(posedge clk) begin
    if (reset && state == S_BURST && wr) ram[{base, beat}] <= to_mem;
    rd_q <= ram[{base, rd_beat}];
  end
  assign mem_ready  = state == S_BURST;
  assign busy       = state != S_IDLE;
  assign mem_offset = beat;
  assign from_mem   = (mem_ready && !wr) ? rd_q : 16'h0000;
endmodule

// File: tb/tb_burst_mem_responder.sv
// tb_burst_mem_responder: scoreboard bench for burst_mem_responder (default build plus a WAIT_CYCLES=1 build).
module tb_burst_mem_responder;
  localparam int W = 2;
  typedef struct packed {logic [1:0] off; logic [15:0] data;} beat_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mem_req = 1'b0, mem_wren = 1'b0;
  logic [23:0] mem_address = '0;
  logic [15:0] wbase = '0;
  logic [15:0] to_mem, from_mem;
  logic [1:0] mem_offset;
  logic mem_ready, busy;
  logic req1 = 1'b0, wren1 = 1'b0;
  logic [23:0] addr1 = '0;
  logic [15:0] to1, from1;
  logic [1:0] off1;
  logic rdy1, busy1;
  beat_t exp_q[$];
  beat_t e_mon;
  logic [15:0] model [4096];
  int total = 0, bad = 0;
  int ncyc = 0;
  int first_cyc = 0, last_cyc = 0;
  logic mon_en = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;
  assign to_mem = wbase + 16'(mem_offset);
  assign to1 = 16'hC000 + 16'(off1);
  burst_mem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_wren(mem_wren),
    .mem_address(mem_address), .to_mem(to_mem), .from_mem(from_mem),
    .mem_offset(mem_offset), .mem_ready(mem_ready), .busy(busy)
  );
  burst_mem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .mem_req(req1), .mem_wren(wren1),
    .mem_address(addr1), .to_mem(to1), .from_mem(from1),
    .mem_offset(off1), .mem_ready(rdy1), .busy(busy1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (mon_en) begin
      if (mem_ready) begin
        if (exp_q.size() == 0) chk("extra_beat", 32'd1, 32'd0);
        else begin
          e_mon = exp_q.pop_front();
          chk("beat_off", 32'(mem_offset), 32'(e_mon.off));
          chk("beat_data", 32'(from_mem), 32'(e_mon.data));
        end
      end else chk("idle_from", 32'(from_mem), 32'd0);
    end
  task automatic push_exp(input logic wr, input logic [23:0] addr, input logic [15:0] wb, input int nwr);
    for (int k = 0; k < 4; k++) begin
      logic [11:0] idx;
      idx = {addr[11:2], 2'(k)};
      exp_q.push_back('{2'(k), wr ? 16'h0000 : model[idx]});
      if (wr && k < nwr) model[idx] = wb + 16'(k);
    end
  endtask
  task automatic burst(input logic wr, input logic [23:0] addr, input logic [15:0] wb, input int drop,
                       input logic hold, output int lat, output int nbeat, output int nbusy);
    mem_req = 1'b1;
    mem_wren = wr;
    mem_address = addr;
    wbase = wb;
    push_exp(wr, addr, wb, 4);
    lat = 0;
    nbeat = 0;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (mem_ready) begin
        if (nbeat == 0) begin
          lat = i + 1;
          first_cyc = ncyc;
        end
        nbeat++;
        last_cyc = ncyc;
      end
      if (drop == 1 && i == 0) mem_req = 1'b0;
      if (drop == 2 && mem_ready && mem_offset == 2'd1) mem_req = 1'b0;
      if (!hold && nbeat == 4 && !mem_ready) mem_req = 1'b0;
      if (!busy) break;
    end
  endtask
  initial begin
    int lat, nb, nbz, last1, lat1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_off", 32'(mem_offset), 32'd0);
    chk("rst_from", 32'(from_mem), 32'd0);
    reset = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    burst(1'b1, 24'h000010, 16'hA000, 0, 1'b0, lat, nb, nbz);
    chk("t1_lat", 32'(lat), 32'(W + 1));
    chk("t1_beats", 32'(nb), 32'd4);
    chk("t1_busy", 32'(nbz), 32'(W + 5));
    burst(1'b0, 24'h000013, 16'h0000, 0, 1'b0, lat, nb, nbz);
    chk("t2_lat", 32'(lat), 32'(W + 1));
    chk("t2_beats", 32'(nb), 32'd4);
    burst(1'b1, 24'h001004, 16'h1234, 0, 1'b1, lat, nb, nbz);
    last1 = last_cyc;
    burst(1'b0, 24'h000004, 16'h0000, 0, 1'b0, lat, nb, nbz);
    chk("t3_gap", 32'(first_cyc - last1 - 1), 32'(W + 2));
    chk("t3_beats", 32'(nb), 32'd4);
    burst(1'b0, 24'h000010, 16'h0000, 1, 1'b0, lat, nb, nbz);
    chk("t4_wait_beats", 32'(nb), 32'd4);
    burst(1'b0, 24'h001013, 16'h0000, 2, 1'b0, lat, nb, nbz);
    chk("t4_b1_beats", 32'(nb), 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_no_rerun", 32'(busy), 32'd0);
    end
    burst(1'b1, 24'h000020, 16'h5500, 0, 1'b0, lat, nb, nbz);
    mem_req = 1'b1;
    mem_wren = 1'b1;
    mem_address = 24'h000020;
    wbase = 16'h6600;
    push_exp(1'b1, 24'h000020, 16'h6600, 2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_ready && mem_offset == 2'd2) break;
    end
    chk("t5_at_b2", 32'(mem_offset), 32'd2);
    reset = 1'b0;
    mem_req = 1'b0;
    @(negedge clk);
    chk("t5_ready", 32'(mem_ready), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_off", 32'(mem_offset), 32'd0);
    chk("t5_left", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    reset = 1'b1;
    @(negedge clk);
    burst(1'b0, 24'h000020, 16'h0000, 0, 1'b0, lat, nb, nbz);
    chk("t5_beats", 32'(nb), 32'd4);
    req1 = 1'b1;
    wren1 = 1'b1;
    addr1 = 24'h000040;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) req1 = 1'b0;
      if (!busy1) break;
    end
    chk("t6_wr_done", 32'(busy1), 32'd0);
    req1 = 1'b1;
    wren1 = 1'b0;
    lat1 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) req1 = 1'b0;
      if (rdy1) begin
        lat1 = i + 1;
        break;
      end
    end
    chk("t6_lat", 32'(lat1), 32'd2);
    for (int k = 0; k < 4; k++) begin
      chk("t6_ready", 32'(rdy1), 32'd1);
      chk("t6_off", 32'(off1), 32'(k));
      chk("t6_data", 32'(from1), 32'(16'hC000 + 16'(k)));
      @(negedge clk);
    end
    chk("t6_end", 32'(rdy1), 32'd0);
    chk("t6_from0", 32'(from1), 32'd0);
    repeat (2) @(negedge clk);
    chk("q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
